// File: rtl/binary_to_bcd_fsm.sv
// binary_to_bcd_fsm
// Sequential binary-to-BCD converter using the double-dabble algorithm.
// One conversion takes exactly WIDTH shift cycles after the accepting edge,
// followed by a single DONE cycle that pulses 'done' with the new result.
// DIGITS must be large enough that 10**DIGITS > 2**WIDTH - 1, otherwise the
// top decimal digit is lost.
module binary_to_bcd_fsm #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int CAT_W = BCD_W + WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Add 3 to every BCD digit that is 5 or more, so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      nib = v[4*d +: 4];
      if (nib >= 4'd5) begin
        r[4*d +: 4] = nib + 4'd3;
      end else begin
        r[4*d +: 4] = nib;
      end
    end
    return r;
  endfunction

  // One double-dabble step: correct the scratch digits, then shift the
  // combined {scratch, binary} register left by one bit.
  function automatic logic [CAT_W-1:0] dabble_step(input logic [BCD_W-1:0] scratch,
                                                   input logic [WIDTH-1:0] shreg);
    logic [CAT_W-1:0] cat;
    cat = {add3_digits(scratch), shreg};
    return cat << 1;
  endfunction

  // Registered state and datapath.
  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_busy;
  logic               r_done;

  // Next-state values produced by the combinational process.
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [BCD_W-1:0]   w_scratch_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [CAT_W-1:0]   w_step;

  assign w_step = dabble_step(r_scratch, r_shift);

  // Next-state and datapath decode; everything holds unless a transition says otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_scratch_nxt = r_scratch;
    w_cnt_nxt     = r_cnt;
    w_bcd_nxt     = r_bcd;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_shift_nxt   = bin_in;
          w_scratch_nxt = {BCD_W{1'b0}};
          w_cnt_nxt     = CNT_W'(WIDTH);
          w_state_nxt   = ST_SHIFT;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        w_scratch_nxt = w_step[CAT_W-1:WIDTH];
        w_shift_nxt   = w_step[WIDTH-1:0];
        // A zero count cannot occur in SHIFT; treat it as the last step so
        // a corrupted counter can never trap the machine here.
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_bcd_nxt   = w_step[CAT_W-1:WIDTH];
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Status flags are registered alongside the state so they never glitch.
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift, scratch, counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= {WIDTH{1'b0}};
      r_scratch <= {BCD_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_bcd     <= {BCD_W{1'b0}};
    end else begin
      r_shift   <= w_shift_nxt;
      r_scratch <= w_scratch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bcd     <= w_bcd_nxt;
    end
  end

  // Registered busy/done flags that mirror the registered state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bcd_out = r_bcd;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_binary_to_bcd_fsm.sv
// tb_binary_to_bcd_fsm
// Scoreboard bench: the driver pushes the decimal-digit expectation of each
// accepted value; a monitor pops and compares whenever done is seen.
module tb_binary_to_bcd_fsm;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic [BCD_W-1:0] bcd_out;
  logic             busy;
  logic             done;

  int               checks = 0;
  int               failures = 0;
  int               done_seen = 0;
  logic [BCD_W-1:0] exp_q[$];
  logic [BCD_W-1:0] prev_bcd = '0;
  logic [BCD_W-1:0] mon_exp;

  binary_to_bcd_fsm #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits of v by repeated division.
  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int p;
    r = '0;
    p = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: score every done pulse, and check bcd_out holds between pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h expected=none", bcd_out);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("bcd_out", bcd_out, mon_exp);
          for (int d = 0; d < DIGITS; d++) begin
            chk("digit_range", (bcd_out[4*d +: 4] <= 4'd9), 1);
          end
        end
      end else begin
        chk("bcd_hold", bcd_out, prev_bcd);
      end
    end
    prev_bcd = bcd_out;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle actual=busy expected=idle");
    end
  endtask

  // Issue one conversion, scramble bin_in after acceptance, check latency.
  task automatic conv(input int v);
    int n;
    logic [31:0] vv;
    vv = v;
    @(negedge clk);
    wait_idle();
    start  = 1'b1;
    bin_in = vv[WIDTH-1:0];
    exp_q.push_back(ref_bcd(v));
    @(negedge clk);
    start  = 1'b0;
    bin_in = WIDTH'($urandom_range(0, 255));
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, WIDTH + 1);
  endtask

  initial begin
    int busy_cnt;
    int ds0;
    int acc;
    int nd;
    int dcyc[3];

    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #1;
    chk("reset_bcd", bcd_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Basic values, including zero and the top of range.
    conv(0);
    conv(255);
    conv(99);
    conv(128);

    // start re-asserted during SHIFT and DONE must be ignored.
    @(negedge clk);
    wait_idle();
    start  = 1'b1;
    bin_in = 8'd37;
    exp_q.push_back(ref_bcd(37));
    ds0 = done_seen;
    busy_cnt = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (j <= 9) begin
        start  = 1'b1;
        bin_in = 8'd200;
      end else begin
        start  = 1'b0;
      end
    end
    chk("busy_cycles", busy_cnt, 9);
    chk("single_done", done_seen - ds0, 1);
    chk("idle_after", busy, 0);

    // start held high: back-to-back conversions.
    @(negedge clk);
    wait_idle();
    start  = 1'b1;
    bin_in = 8'd15;
    acc = 0;
    nd  = 0;
    for (int j = 0; j < 45; j++) begin
      if (done && nd < 3) begin
        dcyc[nd] = j;
        nd++;
      end
      if (!busy && start && acc < 3) begin
        exp_q.push_back(ref_bcd(15));
        acc++;
      end else if (acc == 3) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("held_done_count", nd, 3);
    chk("held_spacing_1", dcyc[1] - dcyc[0], WIDTH + 2);
    chk("held_spacing_2", dcyc[2] - dcyc[1], WIDTH + 2);

    // Reset in the middle of a conversion.
    @(negedge clk);
    wait_idle();
    start  = 1'b1;
    bin_in = 8'd200;
    exp_q.push_back(ref_bcd(200));
    ds0 = done_seen;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_bcd", bcd_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_seen - ds0, 0);
    chk("abort_bcd_held", bcd_out, 0);
    conv(200);

    // Exhaustive sweep followed by random values.
    for (int v = 0; v < 256; v++) begin
      conv(v);
    end
    for (int r = 0; r < 20; r++) begin
      conv(int'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/binary_to_bcd_fsm.md
BINARY_TO_BCD_FSM -- requirements
Module: binary_to_bcd_fsm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the binary input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 3, the number of BCD output digits; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port start, input, 1 bit, the conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port bin_in, input, WIDTH bits, the unsigned binary value, captured on the accepting edge.
REQ-007 The block SHALL have port bcd_out, output, 4*DIGITS bits, packed BCD with the most significant digit in the top nibble.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a new valid bcd_out.

Function
REQ-010 The block SHALL implement three states, IDLE, SHIFT and DONE, held in a registered state variable.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL capture bin_in into a shift register, clear the BCD scratch register, load the bit counter with WIDTH, and enter SHIFT.
REQ-012 In IDLE with start=0, the block SHALL hold all registers and outputs.
REQ-013 Each SHIFT edge SHALL add 3 to every scratch digit that is >=5, then shift {scratch, shift register} left by 1 (double-dabble), and decrement the counter.
REQ-014 On the SHIFT edge where the counter goes from 1 to 0, the block SHALL load the final scratch result into bcd_out and enter DONE.
REQ-015 The latency SHALL be exactly WIDTH SHIFT cycles; done SHALL be high in the cycle after edge k+WIDTH when start was accepted at edge k (cycle k+WIDTH+1).
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-017 start SHALL be ignored in SHIFT and DONE; a request asserted in DONE is not queued, and a start held high is accepted on the first IDLE edge.
REQ-018 bcd_out SHALL change only on the final SHIFT edge and hold its value until the next completed conversion; intermediate scratch values SHALL never appear on bcd_out.
REQ-019 Every bcd_out digit SHALL be in 0..9 for any bin_in in 0..2^WIDTH-1.
REQ-020 Changes on bin_in after the accepting edge SHALL NOT affect the conversion in progress.
REQ-021 done and busy SHALL be decoded from registered state only and SHALL be glitch-free.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for clk, force state=IDLE, bcd_out=0, busy=0, done=0, and clear the counter, shift and scratch registers.
REQ-023 Reset asserted mid-conversion SHALL abort it with no done pulse; bcd_out SHALL read 0.
REQ-024 After reset is released, the first rising edge with start=1 SHALL start a fresh conversion.

Verification
REQ-025 The bench SHALL cover: reset=0 then released, start=1 with bin_in=0 -> done after 8 SHIFT cycles, bcd_out=12'h000.
REQ-026 The bench SHALL cover: bin_in=255 -> bcd_out=12'h255 (0010 0101 0101); bin_in=99 -> 12'h099; bin_in=128 -> 12'h128.
REQ-027 The bench SHALL cover: start pulsed with bin_in=37, then start=1 with bin_in=200 during SHIFT -> done once, bcd_out=12'h037, busy high for 9 cycles.
REQ-028 The bench SHALL cover: start held high continuously with bin_in=15 -> conversions back-to-back with one IDLE cycle between done pulses, each bcd_out=12'h015.
REQ-029 The bench SHALL cover: reset=0 asserted after 4 SHIFT cycles of bin_in=200 -> outputs zero asynchronously, no done pulse; after release, bin_in=200 -> 12'h200.
REQ-030 The bench SHALL cover: an exhaustive sweep of bin_in 0..255 -> each bcd_out equals the decimal digits of bin_in, every nibble <=9.
